// File: rtl/useq_sequencer.sv
// Microcode sequencer: next micro-address from control word and flags,
// with a micro-call stack and two-page (escape) opcode dispatch.
module useq_sequencer #(
  parameter int CW_WIDTH       = 112,
  parameter int OPC_WIDTH      = 8,
  parameter int STEP_LOG2      = 6,
  parameter int UADDR_WIDTH    = 15,
  parameter int OFFSET_WIDTH   = 7,
  parameter int COND_SEL_WIDTH = 4,
  parameter int STACK_DEPTH    = 4,
  parameter int FETCH_ADDR     = 0,
  parameter int TYP_POS        = 0,
  parameter int OFFSET_POS     = 2,
  parameter int COND_INV_POS   = 9,
  parameter int COND_SRC_POS   = 10,
  parameter int COND_SEL_POS   = 11,
  parameter int ESCAPE_POS     = 15,
  parameter int CALL_POS       = 98,
  parameter int RET_POS        = 99
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CW_WIDTH-1:0]                cw_i,
  input  logic [OPC_WIDTH-1:0]               opcode_i,
  input  logic [2**COND_SEL_WIDTH-1:0]       cond_a_i,
  input  logic [2**COND_SEL_WIDTH-1:0]       cond_b_i,
  input  logic                               hold_i,
  output logic [UADDR_WIDTH-1:0]             uaddr_o,
  output logic                               page_o,
  output logic                               cond_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_lvl_o,
  output logic                               err_o
);

  localparam int LVL_W = $clog2(STACK_DEPTH+1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [UADDR_WIDTH-1:0] FETCH = UADDR_WIDTH'(FETCH_ADDR);
  localparam logic [UADDR_WIDTH-1:0] ONE   = UADDR_WIDTH'(1);

  logic [UADDR_WIDTH-1:0] uaddr_q, uaddr_d;
  logic                   page_q, page_d;
  logic [LVL_W-1:0]       lvl_q, lvl_d;
  logic                   err_q, err_d;
  logic [UADDR_WIDTH-1:0] stk_q [STACK_DEPTH];
  logic                   push;

  logic [1:0]                  typ;
  logic [OFFSET_WIDTH-1:0]     off;
  logic [COND_SEL_WIDTH-1:0]   sel;
  logic [2**COND_SEL_WIDTH-1:0] bank;
  logic                        call, ret;
  logic [UADDR_WIDTH-1:0]      off_x, target, incr;
  logic                        full, empty;
  logic [PTR_W-1:0]            wptr, rptr;
  logic                        unused_cw;

  assign typ  = cw_i[TYP_POS +: 2];
  assign off  = cw_i[OFFSET_POS +: OFFSET_WIDTH];
  assign sel  = cw_i[COND_SEL_POS +: COND_SEL_WIDTH];
  assign call = cw_i[CALL_POS];
  assign ret  = cw_i[RET_POS];
  assign bank = cw_i[COND_SRC_POS] ? cond_b_i : cond_a_i;
  assign cond_o = bank[sel] ^ cw_i[COND_INV_POS];
  assign unused_cw = ^cw_i;

  assign off_x  = {{(UADDR_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
  assign target = uaddr_q + off_x;
  assign incr   = uaddr_q + ONE;
  assign full   = (lvl_q == LVL_W'(STACK_DEPTH));
  assign empty  = (lvl_q == '0);
  assign wptr   = lvl_q[PTR_W-1:0];
  assign rptr   = PTR_W'(lvl_q - LVL_W'(1));

  always_comb begin
    uaddr_d = uaddr_q;
    page_d  = page_q;
    lvl_d   = lvl_q;
    err_d   = err_q;
    push    = 1'b0;
    if (ret) begin
      // Return wins over a simultaneous call; the call is dropped as an error
      if (call || empty) err_d = 1'b1;
      if (empty) begin
        uaddr_d = FETCH;
      end else begin
        uaddr_d = stk_q[rptr];
        lvl_d   = lvl_q - LVL_W'(1);
      end
    end else if (call) begin
      if (full) begin
        uaddr_d = incr;
        err_d   = 1'b1;
      end else begin
        push    = 1'b1;
        uaddr_d = target;
        lvl_d   = lvl_q + LVL_W'(1);
      end
    end else begin
      unique case (typ)
        2'b00: uaddr_d = target;
        2'b01: uaddr_d = cond_o ? target : incr;
        2'b10: begin
          uaddr_d = {page_q, opcode_i, {STEP_LOG2{1'b0}}};
          page_d  = cw_i[ESCAPE_POS];
        end
        2'b11: uaddr_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr_q <= FETCH;
      page_q  <= 1'b0;
      lvl_q   <= '0;
      err_q   <= 1'b0;
    end else if (!hold_i) begin
      uaddr_q <= uaddr_d;
      page_q  <= page_d;
      lvl_q   <= lvl_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !hold_i && push) stk_q[wptr] <= incr;
  end

  assign uaddr_o   = uaddr_q;
  assign page_o    = page_q;
  assign stk_lvl_o = lvl_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_useq_sequencer.sv
// Bench for useq_sequencer: vector table, hand-built call/hold
// sequences and a randomized run against a queue-based model.
module tb_useq_sequencer;
  localparam int CW = 112;
  localparam int UW = 15;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst, hold;
  logic [CW-1:0] cw;
  logic [7:0] opc;
  logic [15:0] ca, cb;
  logic [UW-1:0] uaddr;
  logic page, cond, err;
  logic [LW-1:0] lvl;

  int total = 0;
  int bad = 0;

  int m_u, m_page, m_err;
  int m_stk[$];

  always #5 clk = ~clk;

  useq_sequencer dut (
    .clk(clk), .rst(rst), .cw_i(cw), .opcode_i(opc),
    .cond_a_i(ca), .cond_b_i(cb), .hold_i(hold),
    .uaddr_o(uaddr), .page_o(page), .cond_o(cond),
    .stk_lvl_o(lvl), .err_o(err)
  );

  typedef struct {
    int typ, off, esc, inv, src, sel, op, a, b;
    int eu, ep, ec;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [CW-1:0] mk_cw(int typ, int off, bit call,
      bit ret, bit esc, bit inv, bit src, int sel);
    logic [CW-1:0] w;
    w = '0;
    w[1:0] = typ[1:0];
    w[8:2] = off[6:0];
    w[9] = inv;
    w[10] = src;
    w[14:11] = sel[3:0];
    w[15] = esc;
    w[98] = call;
    w[99] = ret;
    return w;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(string nm, int u, int p, int l, int e);
    chk({nm, ".uaddr"}, 32'(uaddr), u);
    chk({nm, ".page"}, 32'(page), p);
    chk({nm, ".lvl"}, 32'(lvl), l);
    chk({nm, ".err"}, 32'(err), e);
  endtask

  task automatic drive(logic [CW-1:0] c, int op, int a, int b,
      bit h, bit r);
    cw = c;
    opc = op[7:0];
    ca = a[15:0];
    cb = b[15:0];
    hold = h;
    rst = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit mcond(logic [CW-1:0] c, int a, int b);
    int bk, s;
    bk = c[10] ? b : a;
    s = int'(c[14:11]);
    return bit'((bk >> s) & 1) ^ c[9];
  endfunction

  task automatic model_step(logic [CW-1:0] c, int op, int a, int b,
      bit h, bit r);
    int off, tgt, nxt;
    off = int'(c[8:2]);
    if (off > 63) off -= 128;
    tgt = (m_u + off) & 'h7FFF;
    nxt = (m_u + 1) & 'h7FFF;
    if (r) begin
      m_u = 0; m_page = 0; m_err = 0;
      m_stk.delete();
    end else if (!h) begin
      if (c[99]) begin
        if (c[98]) m_err = 1;
        if (m_stk.size() == 0) begin
          m_u = 0; m_err = 1;
        end else m_u = m_stk.pop_back();
      end else if (c[98]) begin
        if (m_stk.size() == 4) begin
          m_u = nxt; m_err = 1;
        end else begin
          m_stk.push_back(nxt);
          m_u = tgt;
        end
      end else begin
        case (int'(c[1:0]))
          0: m_u = tgt;
          1: m_u = mcond(c, a, b) ? tgt : nxt;
          2: begin
            m_u = m_page * 16384 + op * 64;
            m_page = int'(c[15]);
          end
          default: m_u = 0;
        endcase
      end
    end
  endtask

  task automatic do_reset(bit h);
    drive('0, 0, 0, 0, h, 1'b1);
    tick;
  endtask

  initial begin
    drive('0, 0, 0, 0, 1'b0, 1'b1);
    tick;
    tick;
    chk_state("rst", 0, 0, 0, 0);

    tbl[0]  = '{0, 'h7E, 0, 0, 0, 0, 0, 0, 0, 'h7FFE, 0, -1};
    tbl[1]  = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 'h0001, 0, -1};
    tbl[2]  = '{0, 15, 0, 0, 0, 0, 0, 0, 0, 'h0010, 0, -1};
    tbl[3]  = '{0, 'h7C, 0, 0, 0, 0, 0, 0, 0, 'h000C, 0, -1};
    tbl[4]  = '{2, 0, 0, 0, 0, 0, 'h04, 0, 0, 'h0100, 0, -1};
    tbl[5]  = '{1, 8, 0, 0, 1, 5, 0, 0, 'h20, 'h0108, 0, 1};
    tbl[6]  = '{2, 0, 0, 0, 0, 0, 'h04, 0, 0, 'h0100, 0, -1};
    tbl[7]  = '{1, 8, 0, 1, 1, 5, 0, 0, 'h20, 'h0101, 0, 0};
    tbl[8]  = '{2, 0, 1, 0, 0, 0, 'h2A, 0, 0, 'h0A80, 1, -1};
    tbl[9]  = '{2, 0, 0, 0, 0, 0, 'h2A, 0, 0, 'h4A80, 0, -1};
    tbl[10] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 0, -1};
    tbl[11] = '{1, 5, 0, 0, 0, 3, 0, 'h08, 0, 'h0005, 0, 1};
    tbl[12] = '{1, 5, 0, 0, 0, 3, 0, 0, 'hFFFF, 'h0006, 0, 0};
    tbl[13] = '{2, 0, 1, 0, 0, 0, 'h2A, 0, 0, 'h0A80, 1, -1};
    tbl[14] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 1, -1};
    tbl[15] = '{2, 0, 0, 0, 0, 0, 'h01, 0, 0, 'h4040, 0, -1};

    for (int i = 0; i < 16; i++) begin
      drive(mk_cw(tbl[i].typ, tbl[i].off, 0, 0, bit'(tbl[i].esc),
                  bit'(tbl[i].inv), bit'(tbl[i].src), tbl[i].sel),
            tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
      #1;
      if (tbl[i].ec >= 0) chk($sformatf("vec%0d.cond", i), 32'(cond), tbl[i].ec);
      tick;
      chk_state($sformatf("vec%0d", i), tbl[i].eu, tbl[i].ep, 0, 0);
    end

    // nested calls up to overflow, then unwind past empty
    do_reset(1'b0);
    drive(mk_cw(2, 0, 0, 0, 0, 0, 0, 0), 'h08, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("cr.disp", 'h200, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(mk_cw(0, 16, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
      tick;
      chk_state($sformatf("cr.call%0d", i), 'h210 + 16 * i, 0, i + 1, 0);
    end
    drive(mk_cw(0, 16, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("cr.full", 'h241, 0, 4, 1);
    for (int i = 0; i < 4; i++) begin
      drive(mk_cw(0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
      tick;
      chk_state($sformatf("cr.ret%0d", i), 'h231 - 16 * i, 0, 3 - i, 1);
    end
    drive(mk_cw(0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("cr.empty", 0, 0, 0, 1);

    // hold freezes state, then CALL+RET together
    do_reset(1'b0);
    chk_state("rst2", 0, 0, 0, 0);
    drive(mk_cw(2, 0, 0, 0, 1, 0, 0, 0), 'h04, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("hd.disp", 'h100, 1, 0, 0);
    drive(mk_cw(0, 8, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("hd.call", 'h108, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(mk_cw(1, 8, 0, 0, 0, 0, 1, 5), 0, 0, 'h20, 1'b1, 1'b0);
      tick;
      chk_state($sformatf("hd.hold%0d", i), 'h108, 1, 1, 0);
    end
    drive(mk_cw(0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("hd.ret", 'h101, 1, 0, 0);
    drive(mk_cw(0, 8, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    drive(mk_cw(0, 8, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("cc.pre", 'h111, 1, 2, 0);
    drive(mk_cw(0, 8, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("cc.both", 'h10A, 1, 1, 1);

    // reset while holding, stack discarded
    do_reset(1'b1);
    chk_state("rsthold", 0, 0, 0, 0);
    drive(mk_cw(0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1'b0, 1'b0);
    tick;
    chk_state("rst.pop", 0, 0, 0, 1);

    do_reset(1'b0);
    m_u = 0; m_page = 0; m_err = 0;
    m_stk.delete();
    for (int n = 0; n < 3000; n++) begin
      logic [127:0] big;
      logic [CW-1:0] c;
      int op, a, b;
      bit h, r;
      big = {$urandom, $urandom, $urandom, $urandom};
      c = big[CW-1:0];
      c[98] = ($urandom_range(0, 4) == 0);
      c[99] = ($urandom_range(0, 5) == 0);
      op = int'($urandom_range(0, 255));
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      h = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 99) == 0);
      drive(c, op, a, b, h, r);
      #1;
      chk("rnd.cond", 32'(cond), 32'(mcond(c, a, b)));
      tick;
      model_step(c, op, a, b, h, r);
      chk_state("rnd", m_u, m_page, m_stk.size(), m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/useq_sequencer.md
Name: useq_sequencer

Overview:
- Parametrised microcode sequencer: computes the next micro-address from the current control word and CPU condition flags, and drives the microcode ROM address.
- Successor to the fixed 14-ROM control-word layout: control word width, field positions, address width and condition count are all parameters.
- Adds a micro-subroutine call/return stack and a two-page opcode dispatch (escape prefix).
- Sits between IR/flag logic and the microcode ROM bank. The ROM is external and asynchronous-read, so cw_i is valid in the same cycle as uaddr_o.

Parameters:
CW_WIDTH, 112, control word width in bits (8 x ROM count)
OPC_WIDTH, 8, opcode width
STEP_LOG2, 6, log2 of micro-steps per opcode
UADDR_WIDTH, 15, micro-address width; must equal 1+OPC_WIDTH+STEP_LOG2
OFFSET_WIDTH, 7, signed offset field width
COND_SEL_WIDTH, 4, condition select width; 2**COND_SEL_WIDTH conditions per bank
STACK_DEPTH, 4, micro-call stack entries
FETCH_ADDR, 0, micro-address of the fetch routine
TYP_POS, 0, LSB of 2-bit typ field
OFFSET_POS, 2, LSB of offset field
COND_INV_POS, 9, condition invert bit
COND_SRC_POS, 10, condition bank select bit
COND_SEL_POS, 11, LSB of condition select field
ESCAPE_POS, 15, escape bit
CALL_POS, 98, micro-call bit
RET_POS, 99, micro-return bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cw_i  in  CW_WIDTH  control word read from ROM at uaddr_o
opcode_i  in  OPC_WIDTH  current IR opcode
cond_a_i  in  2**COND_SEL_WIDTH  bank 0 conditions (status flags)
cond_b_i  in  2**COND_SEL_WIDTH  bank 1 conditions (ALU/MSW flags)
hold_i  in  1  stall: freeze all state
uaddr_o  out  UADDR_WIDTH  registered micro-address
page_o  out  1  current dispatch page
cond_o  out  1  evaluated condition for the current cw_i (combinational)
stk_lvl_o  out  clog2(STACK_DEPTH+1)  stack occupancy
err_o  out  1  sticky error flag

Behaviour:
- Reset (clk edge with rst=1, overrides hold_i): uaddr_o=FETCH_ADDR, page_o=0, stk_lvl_o=0, err_o=0. Stack contents are don't-care.
- hold_i=1 (no rst): every register keeps its value.
- Condition evaluation: cond_o = bank[sel] ^ cw_i[COND_INV_POS]. bank = cond_b_i when cw_i[COND_SRC_POS]=1, else cond_a_i.
- Offset arithmetic: off = sign-extended cw_i offset field. Target T = uaddr_o + off, modulo 2**UADDR_WIDTH (wraps silently).
- Next address, first match wins:
  1. RET=1: pop, uaddr <= top entry. If empty: uaddr <= FETCH_ADDR and err_o <= 1. If CALL is also set: err_o <= 1 and CALL is ignored.
  2. CALL=1: push uaddr_o+1 and jump to T. If full: no push, no jump, uaddr <= uaddr_o+1, err_o <= 1.
  3. typ=00 (offset): uaddr <= T.
  4. typ=01 (branch): uaddr <= cond_o ? T : uaddr_o+1.
  5. typ=10 (dispatch): uaddr <= {page_o, opcode_i, STEP_LOG2 zeros}, then page <= cw_i[ESCAPE_POS].
  6. typ=11 (fetch): uaddr <= FETCH_ADDR; page is unchanged.
- Escape applies only on dispatch: page_o is 1 exactly for the dispatch following an escaped dispatch.
- Stack: LIFO with one-cycle push/pop. Push and pop never occur in the same cycle. stk_lvl_o updates on the same edge as uaddr_o.
- err_o is sticky and cleared only by rst.
- Latency: one cycle from cw_i and flags to uaddr_o. No combinational path from cw_i to uaddr_o.
- Reset mid-call discards the stack.

Test Plan:
- Reset: rst=1 then release -> uaddr_o=0x0000, page_o=0, stk_lvl_o=0, err_o=0. Hold with rst=1 also resets.
- Offset wrap:
  - uaddr=0x7FFE, typ=00, off=+3 -> 0x0001.
  - uaddr=0x0010, off=-4 (0x7C) -> 0x000C.
- Branch: sel=5, src=1, cond_b_i[5]=1.
  - inv=0, off=+8 at 0x0100 -> 0x0108.
  - inv=1 -> 0x0101.
- Dispatch: opcode 0x2A, page 0 -> 0x0A80.
  - Dispatch with escape=1, then dispatch opcode 0x2A -> 0x4A80, page_o returns to 0 afterwards.
- Call/return: five nested CALLs from 0x0200 (off=+16 each) -> first four push, stk_lvl_o=4, fifth sets err_o and goes to +1. Four RETs unwind in LIFO order; fifth RET -> 0x0000, err_o stays 1.
- Hold and concurrency: hold_i=1 for 3 cycles during a branch -> uaddr_o, stack and page unchanged. CALL+RET together with level 2 -> pop executed, level 1, err_o=1.
